// File: rtl/crop_filter.sv
// crop_filter: streaming window crop ahead of the Gaussian filter.
//
// Accepts one IN_ROWS x IN_COLS frame in raster order and forwards only the
// OUT_ROWS x OUT_COLS window whose top-left corner is (Y1, X1). The corner is
// taken per frame from two side channels while idle. Pixels outside the
// window are consumed and dropped. In-window pixels are forwarded unchanged
// through one output register, so they appear one cycle after acceptance.
//
// Optional build macro: CROP_CLAMP_EN
//   defined   - the captured corner is clamped so that the window always fits
//               inside the frame.
//   undefined - the corner is used as given, and a window that runs past the
//               frame edge is truncated.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   pixel_in_TDATA/TVALID/TREADY       input pixel stream (raster order)
//   crop_Y1_TDATA/TVALID/TREADY        window top row, one per frame
//   crop_X1_TDATA/TVALID/TREADY        window left column, one per frame
//   pixel_out_TDATA/TVALID/TREADY      cropped pixel stream
module crop_filter #(
  parameter int unsigned PIXEL_BIT_WIDTH  = 16,
  parameter int unsigned IN_ROWS          = 100,
  parameter int unsigned IN_COLS          = 160,
  parameter int unsigned OUT_ROWS         = 48,
  parameter int unsigned OUT_COLS         = 48,
  parameter int unsigned IMG_ROW_BITWIDTH = 10,
  parameter int unsigned IMG_COL_BITWIDTH = 10
) (
  input  logic                        clk,
  input  logic                        reset,

  input  logic [PIXEL_BIT_WIDTH-1:0]  pixel_in_TDATA,
  input  logic                        pixel_in_TVALID,
  output logic                        pixel_in_TREADY,

  input  logic [IMG_ROW_BITWIDTH-1:0] crop_Y1_TDATA,
  input  logic                        crop_Y1_TVALID,
  output logic                        crop_Y1_TREADY,

  input  logic [IMG_COL_BITWIDTH-1:0] crop_X1_TDATA,
  input  logic                        crop_X1_TVALID,
  output logic                        crop_X1_TREADY,

  output logic [PIXEL_BIT_WIDTH-1:0]  pixel_out_TDATA,
  output logic                        pixel_out_TVALID,
  input  logic                        pixel_out_TREADY
);

  typedef logic [IMG_ROW_BITWIDTH-1:0] row_t;
  typedef logic [IMG_COL_BITWIDTH-1:0] col_t;
  // One bit wider so that corner + window size cannot wrap.
  typedef logic [IMG_ROW_BITWIDTH:0]   row_ext_t;
  typedef logic [IMG_COL_BITWIDTH:0]   col_ext_t;

  localparam row_t     LastRow = row_t'(IN_ROWS - 1);
  localparam col_t     LastCol = col_t'(IN_COLS - 1);
  localparam row_ext_t WinRows = row_ext_t'(OUT_ROWS);
  localparam col_ext_t WinCols = col_ext_t'(OUT_COLS);

  typedef enum logic {StIdle, StStream} state_e;

  state_e                     state_q;
  row_t                       row_q;
  col_t                       col_q;
  row_t                       y1_q;
  col_t                       x1_q;
  logic                       y1_vld_q;
  logic                       x1_vld_q;
  logic [PIXEL_BIT_WIDTH-1:0] out_data_q;
  logic                       out_vld_q;

  logic y1_xfer, x1_xfer, pix_xfer;
  logic in_window, last_pixel;
  row_t y1_cap;
  col_t x1_cap;

`ifdef CROP_CLAMP_EN
  localparam row_t MaxY1 = row_t'(IN_ROWS - OUT_ROWS);
  localparam col_t MaxX1 = col_t'(IN_COLS - OUT_COLS);
  assign y1_cap = (crop_Y1_TDATA > MaxY1) ? MaxY1 : crop_Y1_TDATA;
  assign x1_cap = (crop_X1_TDATA > MaxX1) ? MaxX1 : crop_X1_TDATA;
`else
  assign y1_cap = crop_Y1_TDATA;
  assign x1_cap = crop_X1_TDATA;
`endif

  // READYs depend only on state and the downstream READY, never on the
  // same channel's VALID. All of them are held low while reset is asserted.
  assign crop_Y1_TREADY  = !reset && (state_q == StIdle) && !y1_vld_q;
  assign crop_X1_TREADY  = !reset && (state_q == StIdle) && !x1_vld_q;
  assign pixel_in_TREADY = !reset && (state_q == StStream) &&
                           (!out_vld_q || pixel_out_TREADY);

  assign y1_xfer  = crop_Y1_TVALID && crop_Y1_TREADY;
  assign x1_xfer  = crop_X1_TVALID && crop_X1_TREADY;
  assign pix_xfer = pixel_in_TVALID && pixel_in_TREADY;

  always_comb begin
    in_window = (row_q >= y1_q) &&
                (row_ext_t'(row_q) < (row_ext_t'(y1_q) + WinRows)) &&
                (col_q >= x1_q) &&
                (col_ext_t'(col_q) < (col_ext_t'(x1_q) + WinCols));
    last_pixel = (row_q == LastRow) && (col_q == LastCol);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      row_q      <= '0;
      col_q      <= '0;
      y1_q       <= '0;
      x1_q       <= '0;
      y1_vld_q   <= 1'b0;
      x1_vld_q   <= 1'b0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (y1_xfer) begin
            y1_q     <= y1_cap;
            y1_vld_q <= 1'b1;
          end
          if (x1_xfer) begin
            x1_q     <= x1_cap;
            x1_vld_q <= 1'b1;
          end
          // Leave only once both corner values are already registered.
          if (y1_vld_q && x1_vld_q) state_q <= StStream;
        end
        StStream: begin
          if (pix_xfer) begin
            if (last_pixel) begin
              row_q    <= '0;
              col_q    <= '0;
              y1_q     <= '0;
              x1_q     <= '0;
              y1_vld_q <= 1'b0;
              x1_vld_q <= 1'b0;
              state_q  <= StIdle;
            end else if (col_q == LastCol) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      // The output register is independent of state, so a pixel still
      // pending at end of frame stays valid in idle until it is taken.
      if (pix_xfer && in_window) begin
        out_data_q <= pixel_in_TDATA;
        out_vld_q  <= 1'b1;
      end else if (pixel_out_TREADY) begin
        out_vld_q  <= 1'b0;
      end
    end
  end

  assign pixel_out_TDATA  = out_data_q;
  assign pixel_out_TVALID = out_vld_q;

endmodule

// File: tb/tb_crop_filter.sv
// Self-checking bench for crop_filter on a 20x32 frame with an 8x12 window.
// Input pixel value equals its raster index, so every output identifies its
// source position.
module tb_crop_filter;

  localparam int PW    = 16;
  localparam int IR    = 20;
  localparam int IC    = 32;
  localparam int OR    = 8;
  localparam int OC    = 12;
  localparam int RW    = 10;
  localparam int CW    = 10;
  localparam int TOTAL = IR * IC;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] pixel_in_TDATA;
  logic          pixel_in_TVALID;
  logic          pixel_in_TREADY;
  logic [RW-1:0] crop_Y1_TDATA;
  logic          crop_Y1_TVALID;
  logic          crop_Y1_TREADY;
  logic [CW-1:0] crop_X1_TDATA;
  logic          crop_X1_TVALID;
  logic          crop_X1_TREADY;
  logic [PW-1:0] pixel_out_TDATA;
  logic          pixel_out_TVALID;
  logic          pixel_out_TREADY;

  always #5 clk = ~clk;

  crop_filter #(
    .PIXEL_BIT_WIDTH (PW),
    .IN_ROWS         (IR),
    .IN_COLS         (IC),
    .OUT_ROWS        (OR),
    .OUT_COLS        (OC),
    .IMG_ROW_BITWIDTH(RW),
    .IMG_COL_BITWIDTH(CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pixel_in_TDATA  (pixel_in_TDATA),
    .pixel_in_TVALID (pixel_in_TVALID),
    .pixel_in_TREADY (pixel_in_TREADY),
    .crop_Y1_TDATA   (crop_Y1_TDATA),
    .crop_Y1_TVALID  (crop_Y1_TVALID),
    .crop_Y1_TREADY  (crop_Y1_TREADY),
    .crop_X1_TDATA   (crop_X1_TDATA),
    .crop_X1_TVALID  (crop_X1_TVALID),
    .crop_X1_TREADY  (crop_X1_TREADY),
    .pixel_out_TDATA (pixel_out_TDATA),
    .pixel_out_TVALID(pixel_out_TVALID),
    .pixel_out_TREADY(pixel_out_TREADY)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  typedef struct {
    int y1;
    int x1;
    int vpct;
    int rpct;
    int cnt;
    int first;
    int last;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  // Reference list of expected outputs, walked directly from the window definition.
  function automatic void build_expected(input int y1, input int x1);
    int ey, ex;
    ey = y1;
    ex = x1;
`ifdef CROP_CLAMP_EN
    if (ey > IR - OR) ey = IR - OR;
    if (ex > IC - OC) ex = IC - OC;
`endif
    exp_q.delete();
    for (int r = 0; r < IR; r++)
      for (int c = 0; c < IC; c++)
        if (r >= ey && r < ey + OR && c >= ex && c < ex + OC) exp_q.push_back(r * IC + c);
  endfunction

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    reset            = 1'b1;
    pixel_in_TVALID  = 1'b0;
    crop_Y1_TVALID   = 1'b0;
    crop_X1_TVALID   = 1'b0;
    pixel_out_TREADY = 1'b1;
    @(posedge clk);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      #1;
      check("rst_out_valid", pixel_out_TVALID, 0);
      check("rst_out_data", pixel_out_TDATA, 0);
      check("rst_rdy", {crop_Y1_TREADY, crop_X1_TREADY, pixel_in_TREADY}, 0);
    end
    reset = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    #1;
    check({tag, "_idle_y1_rdy"}, crop_Y1_TREADY, 1);
    check({tag, "_idle_x1_rdy"}, crop_X1_TREADY, 1);
    check({tag, "_idle_pix_rdy"}, pixel_in_TREADY, 0);
    check({tag, "_idle_out_vld"}, pixel_out_TVALID, 0);
  endtask

  // Runs one frame with random VALID/READY. stall_at >= 0 freezes the sink for
  // 20 cycles once that many outputs have been taken; abort_after >= 0 stops
  // feeding after that many input pixels (the caller then resets).
  task automatic run_frame(input string tag, input int y1, input int x1, input int vpct,
                           input int rpct, input int stall_at, input int abort_after,
                           output int cnt, output int first, output int last);
    int   pix_sent   = 0;
    bit   y1_done    = 0;
    bit   x1_done    = 0;
    bit   pix_acc    = 0;
    bit   stalled    = 0;
    int   stall_left = 0;
    int   cycles     = 0;
    int   budget     = TOTAL * 40 + 200;
    logic [PW-1:0] stall_data = '0;
    int   e;
    cnt   = 0;
    first = -1;
    last  = -1;
    build_expected(y1, x1);
    crop_Y1_TDATA = RW'(y1);
    crop_X1_TDATA = CW'(x1);
    forever begin
      @(negedge clk);
      if (abort_after >= 0 && pix_sent >= abort_after) break;
      if (pix_sent == TOTAL && !pixel_out_TVALID) break;
      if (cycles++ > budget) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_timeout: %0d pixels sent, %0d outputs, budget %0d cycles",
                 tag, pix_sent, cnt, budget);
        break;
      end
      if (y1_done) crop_Y1_TVALID = 1'b0;
      else if (!crop_Y1_TVALID) crop_Y1_TVALID = ($urandom_range(99) < vpct);
      if (x1_done) crop_X1_TVALID = 1'b0;
      else if (!crop_X1_TVALID) crop_X1_TVALID = ($urandom_range(99) < vpct);
      if (pix_acc) pixel_in_TVALID = 1'b0;
      pix_acc = 0;
      if (pix_sent < TOTAL && !pixel_in_TVALID) begin
        pixel_in_TVALID = ($urandom_range(99) < vpct);
        pixel_in_TDATA  = PW'(pix_sent);
      end
      if (stall_at >= 0 && !stalled && cnt == stall_at && pixel_out_TVALID) begin
        stalled    = 1;
        stall_left = 20;
        stall_data = pixel_out_TDATA;
      end
      if (stall_left > 0) pixel_out_TREADY = 1'b0;
      else pixel_out_TREADY = ($urandom_range(99) < rpct);
      #1;
      if (stall_left > 0) begin
        check({tag, "_stall_vld"}, pixel_out_TVALID, 1);
        check({tag, "_stall_data"}, pixel_out_TDATA, stall_data);
        check({tag, "_stall_in_rdy"}, pixel_in_TREADY, 0);
        stall_left--;
      end
      if (crop_Y1_TVALID && crop_Y1_TREADY) y1_done = 1;
      if (crop_X1_TVALID && crop_X1_TREADY) x1_done = 1;
      if (pixel_in_TVALID && pixel_in_TREADY) begin
        pix_sent++;
        pix_acc = 1;
      end
      if (pixel_out_TVALID && pixel_out_TREADY) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check({tag, "_data"}, pixel_out_TDATA, e);
        cnt++;
        if (cnt == 1) first = int'(pixel_out_TDATA);
        last = int'(pixel_out_TDATA);
      end
    end
    pixel_in_TVALID = 1'b0;
    crop_Y1_TVALID  = 1'b0;
    crop_X1_TVALID  = 1'b0;
    if (abort_after < 0) check({tag, "_missing"}, exp_q.size(), 0);
  endtask

  initial begin
    int cnt, first, last;

    // y1, x1, valid%, ready%, expected count, first, last
    vecs[0] = '{3, 4, 70, 70, 96, 100, 335};
    vecs[1] = '{0, 0, 100, 100, 96, 0, 235};
    vecs[2] = '{12, 20, 80, 50, 96, 404, 639};
`ifdef CROP_CLAMP_EN
    vecs[3] = '{17, 28, 90, 90, 96, 404, 639};
    vecs[4] = '{25, 40, 90, 90, 96, 404, 639};
`else
    vecs[3] = '{17, 28, 90, 90, 12, 572, 639};
    vecs[4] = '{25, 40, 90, 90, 0, -1, -1};
`endif

    reset            = 1'b1;
    pixel_in_TDATA   = '0;
    pixel_in_TVALID  = 1'b0;
    crop_Y1_TDATA    = '0;
    crop_Y1_TVALID   = 1'b0;
    crop_X1_TDATA    = '0;
    crop_X1_TVALID   = 1'b0;
    pixel_out_TREADY = 1'b0;

    do_reset(3);
    check_idle("init");

    for (int i = 0; i < 5; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].y1, vecs[i].x1, vecs[i].vpct, vecs[i].rpct,
                -1, -1, cnt, first, last);
      check($sformatf("vec%0d_count", i), cnt, vecs[i].cnt);
      check($sformatf("vec%0d_first", i), first, vecs[i].first);
      check($sformatf("vec%0d_last", i), last, vecs[i].last);
      check_idle($sformatf("vec%0d", i));
    end

    // Downstream stall mid-window: output frozen, input back-pressured.
    run_frame("stall", 3, 4, 100, 100, 10, -1, cnt, first, last);
    check("stall_count", cnt, 96);
    check("stall_first", first, 100);
    check("stall_last", last, 335);
    check_idle("stall");

    // Reset part-way through a frame, then a clean frame.
    run_frame("abort", 3, 4, 100, 60, -1, 300, cnt, first, last);
    do_reset(3);
    check_idle("post_rst");
    run_frame("after_rst", 3, 4, 60, 80, -1, -1, cnt, first, last);
    check("after_rst_count", cnt, 96);
    check("after_rst_first", first, 100);
    check("after_rst_last", last, 335);
    check_idle("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crop_filter.md
Name: crop_filter

Overview:
- Streaming window-crop stage in the image preprocessing chain, ahead of the Gaussian filter.
- Accepts one full IN_ROWS x IN_COLS frame in raster order (row-major, col fastest) on a valid/ready pixel stream.
- Per frame, accepts a top-left crop corner (Y1, X1) on two side channels.
- Forwards only the OUT_ROWS x OUT_COLS window pixels, unchanged, in raster order; all other pixels are consumed and dropped.

Parameters:
- PIXEL_BIT_WIDTH, 16, pixel data width.
- IN_ROWS, 100, input frame rows.
- IN_COLS, 160, input frame columns.
- OUT_ROWS, 48, crop window rows.
- OUT_COLS, 48, crop window columns.
- IMG_ROW_BITWIDTH, 10, row counter / crop_Y1 width; must hold IN_ROWS-1.
- IMG_COL_BITWIDTH, 10, column counter / crop_X1 width; must hold IN_COLS-1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- pixel_in_TDATA  in  PIXEL_BIT_WIDTH  input pixel.
- pixel_in_TVALID  in  1  input pixel valid.
- pixel_in_TREADY  out  1  block accepts input pixel.
- crop_Y1_TDATA  in  IMG_ROW_BITWIDTH  window top row.
- crop_Y1_TVALID  in  1  Y1 valid.
- crop_Y1_TREADY  out  1  Y1 accepted.
- crop_X1_TDATA  in  IMG_COL_BITWIDTH  window left column.
- crop_X1_TVALID  in  1  X1 valid.
- crop_X1_TREADY  out  1  X1 accepted.
- pixel_out_TDATA  out  PIXEL_BIT_WIDTH  cropped pixel.
- pixel_out_TVALID  out  1  output valid.
- pixel_out_TREADY  in  1  downstream ready.

Behaviour:
- Transfer rule: a transfer occurs on a rising edge when VALID and READY are both 1. READY never depends combinationally on the same channel's VALID.
- States:
  - IDLE: capturing crop coordinates.
  - STREAM: passing frame pixels.
- IDLE:
  - crop_Y1_TREADY=1 until Y1 is captured; crop_X1_TREADY=1 until X1 is captured. The two are captured independently, in either order or in the same cycle.
  - pixel_in_TREADY=0.
  - Transition to STREAM on the cycle after both are held.
- STREAM:
  - Crop READYs are 0.
  - pixel_in_TREADY = !pixel_out_TVALID || pixel_out_TREADY.
  - Row and column counters advance per accepted pixel; column wraps at IN_COLS-1 and increments row.
- Window test:
  - Y1 <= row < Y1+OUT_ROWS and X1 <= col < X1+OUT_COLS.
  - Sums computed one bit wider than the operands, so there is no wrap.
- Output path:
  - An in-window accepted pixel is loaded into the output register and pixel_out_TVALID is set: 1-cycle latency.
  - An out-of-window pixel is dropped and the output register is unchanged.
  - pixel_out_TVALID clears when the output is taken and no new in-window pixel is loaded that cycle.
  - pixel_out_TDATA is stable while TVALID=1 and TREADY=0.
- End of frame:
  - Acceptance of the pixel at (IN_ROWS-1, IN_COLS-1) resets the counters, clears the captured coordinates and returns to IDLE.
  - A pending output stays valid until taken.
- Coordinates:
  - Callers guarantee Y1 <= IN_ROWS-OUT_ROWS and X1 <= IN_COLS-OUT_COLS; each frame then yields exactly OUT_ROWS*OUT_COLS outputs.
  - Coordinates outside that range: see Optional Feature.
- Reset (also mid-frame):
  - State goes to IDLE; counters, captured flags and coordinates are cleared.
  - pixel_out_TVALID=0 and pixel_out_TDATA=0; the pending output is discarded.
  - All TREADYs are 0 during reset.

Optional Feature:
- Macro: CROP_CLAMP_EN.
- Defined: captured Y1 is clamped to min(Y1, IN_ROWS-OUT_ROWS) and X1 to min(X1, IN_COLS-OUT_COLS). Every frame yields exactly OUT_ROWS*OUT_COLS outputs.
- Undefined: coordinates are used as given. A window extending past the image is truncated at the image edge, so output count = (min(Y1+OUT_ROWS,IN_ROWS)-Y1)*(min(X1+OUT_COLS,IN_COLS)-X1), or 0 if Y1>=IN_ROWS or X1>=IN_COLS.

Test Plan:
- Defaults, input value = raster index, Y1=X1=10, random VALID/READY on all channels:
  - Exactly 2304 outputs.
  - First output 1610, last output 9177.
  - Output k = (10+k/48)*160 + 10 + k%48.
- Y1=0, X1=0 -> first output 0, last 7567, 2304 outputs.
- Y1=52, X1=112 (maximum valid corner) -> first output 8432, last 15999, 2304 outputs; block then returns to IDLE with all TREADYs 0 except the crop channels.
- pixel_out_TREADY held 0 for 20 cycles mid-window -> pixel_out_TDATA/TVALID frozen; pixel_in_TREADY=0 while an output is pending; no data lost.
- Y1=90, X1=150:
  - With CROP_CLAMP_EN: behaves as Y1=52, X1=112.
  - Without: 100 outputs, first 14550, last 15999.
- Reset asserted after 5000 input pixels, then a new frame with Y1=X1=10 -> pixel_out_TVALID=0 during reset; the next frame produces the full 2304-pixel sequence from Test 1.
